// File: rtl/cpu_defs_pkg.sv
// Shared PLCPU front-end definitions: instruction constants, the predictor
// entry layout and the 2-bit saturating counter step.
package cpu_defs;

    localparam int          XLEN     = 32;
    localparam logic [31:0] PC_STEP  = 32'd4;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    // Tags are kept at the widest size any legal table needs (word address
    // with no index bits removed); unused upper bits simply stay zero.
    localparam int BHT_TAG_W = XLEN - 2;

    localparam logic [1:0] CNT_WEAK_NT  = 2'b01;
    localparam logic [1:0] CNT_WEAK_T   = 2'b10;
    localparam logic [1:0] CNT_STRONG_T = 2'b11;
    localparam logic [1:0] CNT_STRONG_NT = 2'b00;

    typedef struct packed {
        logic                 valid;
        logic [BHT_TAG_W-1:0] tag;
        logic [1:0]           cnt;
        logic [XLEN-1:0]      target;
    } bht_entry_t;

    localparam bht_entry_t BHT_ENTRY_RESET = '{
        valid:  1'b0,
        tag:    '0,
        cnt:    CNT_WEAK_NT,
        target: '0
    };

    // Tag of a byte address once the word offset and index bits are dropped.
    function automatic logic [BHT_TAG_W-1:0] pc_tag(input logic [XLEN-1:0] pc, input int idx_w);
        logic [XLEN-1:0] shifted;
        shifted = pc >> (2 + idx_w);
        return shifted[BHT_TAG_W-1:0];
    endfunction

    // One step of a 2-bit saturating counter toward the resolved outcome.
    function automatic logic [1:0] cnt_step(input logic [1:0] cnt, input logic taken);
        logic [1:0] res;
        if (taken) begin
            res = (cnt == CNT_STRONG_T) ? cnt : cnt + 2'd1;
        end else begin
            res = (cnt == CNT_STRONG_NT) ? cnt : cnt - 2'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/if_bht.sv
// Direct-mapped branch history / target table. Lookup is combinational on
// the current fetch PC; updates from EX land on the clock edge, so a lookup
// in the same cycle as an update to the same entry still sees the old entry.
module if_bht
    import cpu_defs::*;
#(
    parameter int ENTRIES = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] lookup_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target
);

    localparam int IDX_W = $clog2(ENTRIES);

    bht_entry_t       entry_q [ENTRIES];
    bht_entry_t       lk_entry;
    bht_entry_t       upd_old;
    bht_entry_t       upd_entry_d;
    logic [IDX_W-1:0] lk_idx;
    logic [IDX_W-1:0] up_idx;
    logic [BHT_TAG_W-1:0] up_tag;

    assign lk_idx   = lookup_pc[2 +: IDX_W];
    assign lk_entry = entry_q[lk_idx];

    assign pred_taken  = lk_entry.valid && (lk_entry.tag == pc_tag(lookup_pc, IDX_W)) && lk_entry.cnt[1];
    assign pred_target = lk_entry.target;

    assign up_idx  = upd_pc[2 +: IDX_W];
    assign up_tag  = pc_tag(upd_pc, IDX_W);
    assign upd_old = entry_q[up_idx];

    // New contents of the entry addressed by the resolving branch: a miss
    // reinstalls the entry weakly biased toward the outcome, a hit trains it.
    always_comb begin
        upd_entry_d = upd_old;
        if (!upd_old.valid || (upd_old.tag != up_tag)) begin
            upd_entry_d.valid = 1'b1;
            upd_entry_d.tag   = up_tag;
            upd_entry_d.cnt   = upd_taken ? CNT_WEAK_T : CNT_WEAK_NT;
        end else begin
            upd_entry_d.cnt   = cnt_step(upd_old.cnt, upd_taken);
        end
        if (upd_taken) begin
            upd_entry_d.target = upd_target;
        end
    end

    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
            // Each entry clears on reset and captures the trained value when addressed.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    entry_q[gi] <= BHT_ENTRY_RESET;
                end else if (upd_valid && (up_idx == IDX_W'(gi))) begin
                    entry_q[gi] <= upd_entry_d;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/if_fetch_unit.sv
// PLCPU instruction-fetch stage: PC register, instruction memory address,
// IF/ID pipeline latch, branch prediction and fetch halt past the program end.
module if_fetch_unit
    import cpu_defs::*;
#(
    parameter int          IMEM_DEPTH    = 1024,
    parameter logic [31:0] MAX_INST_ADDR = 32'h90,
    parameter int          BHT_ENTRIES   = 16,
    parameter logic [31:0] RESET_PC      = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        bht_update,
    input  logic [31:0] bht_update_pc,
    input  logic        bht_update_taken,
    input  logic [31:0] bht_update_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        ifid_valid,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_inst,
    output logic        ifid_pred_taken,
    output logic [31:0] ifid_pred_target,
    output logic        halted
);

    // Never fetch past the last word of instruction memory, even if the
    // configured program end is larger than the memory.
    localparam logic [31:0] IMEM_LAST   = 32'(IMEM_DEPTH * 4 - 4);
    localparam logic [31:0] FETCH_LIMIT = (MAX_INST_ADDR < IMEM_LAST) ? MAX_INST_ADDR : IMEM_LAST;

    logic [31:0] pc_q, pc_d;
    logic        halted_q, halted_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_inst_q, ifid_inst_d;
    logic        ifid_pred_taken_q, ifid_pred_taken_d;
    logic [31:0] ifid_pred_target_q, ifid_pred_target_d;

    logic        pred_taken;
    logic [31:0] pred_target;
    logic [31:0] seq_pc;
    logic [31:0] fetch_next_pc;
    logic [31:0] redirect_aligned;

    if_bht #(
        .ENTRIES (BHT_ENTRIES)
    ) u_bht (
        .clk         (clk),
        .rst         (rst),
        .lookup_pc   (pc_q),
        .pred_taken  (pred_taken),
        .pred_target (pred_target),
        .upd_valid   (bht_update),
        .upd_pc      (bht_update_pc),
        .upd_taken   (bht_update_taken),
        .upd_target  (bht_update_target)
    );

    assign seq_pc           = pc_q + PC_STEP;
    assign fetch_next_pc    = pred_taken ? pred_target : seq_pc;
    assign redirect_aligned = redirect_pc & ~32'h3;

    // Next PC and IF/ID contents: redirect beats halt, halt beats stall.
    always_comb begin
        pc_d               = pc_q;
        halted_d           = halted_q;
        ifid_valid_d       = ifid_valid_q;
        ifid_pc_d          = ifid_pc_q;
        ifid_inst_d        = ifid_inst_q;
        ifid_pred_taken_d  = ifid_pred_taken_q;
        ifid_pred_target_d = ifid_pred_target_q;
        if (redirect_valid || halted_q) begin
            ifid_valid_d       = 1'b0;
            ifid_pc_d          = '0;
            ifid_inst_d        = NOP_INST;
            ifid_pred_taken_d  = 1'b0;
            ifid_pred_target_d = '0;
            if (redirect_valid) begin
                pc_d     = redirect_aligned;
                halted_d = (redirect_aligned > FETCH_LIMIT);
            end
        end else if (!stall) begin
            ifid_valid_d       = 1'b1;
            ifid_pc_d          = pc_q;
            ifid_inst_d        = imem_rdata;
            ifid_pred_taken_d  = pred_taken;
            ifid_pred_target_d = fetch_next_pc;
            pc_d               = fetch_next_pc;
            halted_d           = (fetch_next_pc > FETCH_LIMIT);
        end
    end

    // PC, halt flag and IF/ID latch registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q               <= RESET_PC;
            halted_q           <= 1'b0;
            ifid_valid_q       <= 1'b0;
            ifid_pc_q          <= '0;
            ifid_inst_q        <= NOP_INST;
            ifid_pred_taken_q  <= 1'b0;
            ifid_pred_target_q <= '0;
        end else begin
            pc_q               <= pc_d;
            halted_q           <= halted_d;
            ifid_valid_q       <= ifid_valid_d;
            ifid_pc_q          <= ifid_pc_d;
            ifid_inst_q        <= ifid_inst_d;
            ifid_pred_taken_q  <= ifid_pred_taken_d;
            ifid_pred_target_q <= ifid_pred_target_d;
        end
    end

    assign imem_addr        = pc_q;
    assign halted           = halted_q;
    assign ifid_valid       = ifid_valid_q;
    assign ifid_pc          = ifid_pc_q;
    assign ifid_inst        = ifid_inst_q;
    assign ifid_pred_taken  = ifid_pred_taken_q;
    assign ifid_pred_target = ifid_pred_target_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed stimulus, a fetch-stage model kept in
// plain arithmetic, a per-cycle compare process and literal spot checks.
module tb_if_fetch_unit;

    localparam logic [31:0] MAX = 32'h90;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        bht_update = 1'b0;
    logic [31:0] bht_update_pc = '0;
    logic        bht_update_taken = 1'b0;
    logic [31:0] bht_update_target = '0;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        ifid_valid;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_inst;
    logic        ifid_pred_taken;
    logic [31:0] ifid_pred_target;
    logic        halted;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Model state
    logic [31:0] m_pc, m_ipc, m_inst, m_ptg;
    logic        m_v, m_pt, m_halt;
    bit          m_bv   [16];
    logic [31:0] m_btag [16];
    int          m_bcnt [16];
    logic [31:0] m_btgt [16];

    if_fetch_unit dut (
        .clk               (clk),
        .rst               (rst),
        .stall             (stall),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .bht_update        (bht_update),
        .bht_update_pc     (bht_update_pc),
        .bht_update_taken  (bht_update_taken),
        .bht_update_target (bht_update_target),
        .imem_addr         (imem_addr),
        .imem_rdata        (imem_rdata),
        .ifid_valid        (ifid_valid),
        .ifid_pc           (ifid_pc),
        .ifid_inst         (ifid_inst),
        .ifid_pred_taken   (ifid_pred_taken),
        .ifid_pred_target  (ifid_pred_target),
        .halted            (halted)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] imem_word(input logic [31:0] a);
        return {16'hBEEF, a[15:0]};
    endfunction

    assign imem_rdata = imem_word(imem_addr);

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_ipc = 32'h0; m_inst = NOP; m_ptg = 32'h0;
        m_v = 1'b0; m_pt = 1'b0; m_halt = 1'b0;
        for (int i = 0; i < 16; i++) begin
            m_bv[i] = 1'b0; m_btag[i] = 32'h0; m_bcnt[i] = 1; m_btgt[i] = 32'h0;
        end
    endtask

    // One clock edge of the fetch stage, from the rules: prediction uses the
    // table as it was before this edge's update.
    task automatic model_edge();
        int i;
        bit p;
        logic [31:0] tg, np, a;
        if (!rst) return;
        i  = int'(m_pc[5:2]);
        p  = m_bv[i] && (m_btag[i] == (m_pc >> 6)) && (m_bcnt[i] >= 2);
        tg = m_btgt[i];
        if (redirect_valid) begin
            a = {redirect_pc[31:2], 2'b00};
            m_pc = a; m_halt = (a > MAX); m_v = 1'b0; m_inst = NOP;
        end else if (m_halt) begin
            m_v = 1'b0; m_inst = NOP;
        end else if (!stall) begin
            np = p ? tg : m_pc + 32'd4;
            m_v = 1'b1; m_ipc = m_pc; m_inst = imem_word(m_pc);
            m_pt = p; m_ptg = np; m_pc = np; m_halt = (np > MAX);
        end
        if (bht_update) begin
            i = int'(bht_update_pc[5:2]);
            if (!m_bv[i] || (m_btag[i] != (bht_update_pc >> 6))) begin
                m_bv[i] = 1'b1;
                m_btag[i] = bht_update_pc >> 6;
                m_bcnt[i] = bht_update_taken ? 2 : 1;
            end else if (bht_update_taken) begin
                m_bcnt[i] = (m_bcnt[i] < 3) ? m_bcnt[i] + 1 : 3;
            end else begin
                m_bcnt[i] = (m_bcnt[i] > 0) ? m_bcnt[i] - 1 : 0;
            end
            if (bht_update_taken) m_btgt[i] = bht_update_target;
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk32("imem_addr", imem_addr, m_pc);
            chk1("halted", halted, m_halt);
            chk1("ifid_valid", ifid_valid, m_v);
            chk32("ifid_inst", ifid_inst, m_inst);
            if (m_v) begin
                chk32("ifid_pc", ifid_pc, m_ipc);
                chk1("ifid_pred_taken", ifid_pred_taken, m_pt);
                chk32("ifid_pred_target", ifid_pred_target, m_ptg);
            end
            $display("[TB] t=%0t addr=%h v=%b pc=%h inst=%h pt=%b ptg=%h halt=%b",
                     $time, imem_addr, ifid_valid, ifid_pc, ifid_inst, ifid_pred_taken, ifid_pred_target, halted);
        end
    end

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic redirect_to(input logic [31:0] a);
        redirect_valid = 1'b1;
        redirect_pc = a;
        step();
        redirect_valid = 1'b0;
    endtask

    task automatic bht_train(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
        bht_update = 1'b1;
        bht_update_pc = pc;
        bht_update_taken = taken;
        bht_update_target = tgt;
        step();
        bht_update = 1'b0;
    endtask

    initial begin
        model_reset();
        #12;
        chk1("rst valid", ifid_valid, 1'b0);
        chk32("rst inst", ifid_inst, NOP);
        chk32("rst addr", imem_addr, 32'h0);
        chk1("rst halted", halted, 1'b0);
        chk32("rst pred_target", ifid_pred_target, 32'h0);

        @(negedge clk);
        rst = 1'b1;
        chk_en = 1'b1;
        chk1("valid after release", ifid_valid, 1'b0);

        // Free run
        step();
        chk32("run pc0", ifid_pc, 32'h0);
        chk1("run valid", ifid_valid, 1'b1);
        step();
        chk32("run pc4", ifid_pc, 32'h4);
        chk32("run addr8", imem_addr, 32'h8);

        // Stall at pc=8
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk32("stall addr", imem_addr, 32'h8);
            chk32("stall ifid_pc", ifid_pc, 32'h4);
        end
        stall = 1'b0;
        step();
        chk32("resume ifid_pc", ifid_pc, 32'h8);

        // Redirect beats stall
        stall = 1'b1;
        redirect_to(32'h40);
        chk1("redir bubble", ifid_valid, 1'b0);
        chk32("redir addr", imem_addr, 32'h40);
        stall = 1'b0;
        step();
        chk32("redir ifid_pc", ifid_pc, 32'h40);

        // Train 0x10 taken twice -> strongly taken
        bht_train(32'h10, 1'b1, 32'h30);
        bht_train(32'h10, 1'b1, 32'h30);
        redirect_to(32'h10);
        step();
        chk1("bht taken", ifid_pred_taken, 1'b1);
        chk32("bht target", ifid_pred_target, 32'h30);
        step();
        chk32("bht follow", ifid_pc, 32'h30);

        // One not-taken: still taken; second: not taken
        bht_train(32'h10, 1'b0, 32'h0);
        redirect_to(32'h10);
        step();
        chk1("bht nt1", ifid_pred_taken, 1'b1);
        bht_train(32'h10, 1'b0, 32'h0);
        redirect_to(32'h10);
        step();
        chk1("bht nt2", ifid_pred_taken, 1'b0);
        chk32("bht nt2 target", ifid_pred_target, 32'h14);

        // Update and lookup of the same entry in one cycle sees the old entry
        redirect_to(32'h10);
        bht_train(32'h10, 1'b1, 32'h30);
        chk1("same-cycle old", ifid_pred_taken, 1'b0);
        redirect_to(32'h10);
        step();
        chk1("same-cycle new", ifid_pred_taken, 1'b1);

        // Aliasing branch at 0x50 evicts 0x10's entry
        bht_train(32'h50, 1'b1, 32'h70);
        redirect_to(32'h10);
        step();
        chk1("alias evict", ifid_pred_taken, 1'b0);

        // Misaligned redirect
        redirect_to(32'h23);
        chk32("misalign addr", imem_addr, 32'h20);
        step();
        chk32("misalign ifid_pc", ifid_pc, 32'h20);

        // Halt at program end
        redirect_to(32'h80);
        for (int k = 0; k < 5; k++) step();
        chk32("last fetch pc", ifid_pc, 32'h90);
        chk1("last fetch valid", ifid_valid, 1'b1);
        chk1("halt set", halted, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step();
            chk1("halt bubble", ifid_valid, 1'b0);
            chk32("halt addr", imem_addr, 32'h94);
        end
        redirect_to(32'hA0);
        chk1("oor redirect halts", halted, 1'b1);
        redirect_to(32'h0);
        chk1("in-range redirect clears", halted, 1'b0);
        step();
        chk32("post-halt fetch", ifid_pc, 32'h0);

        // Mid-redirect asynchronous reset
        bht_train(32'h10, 1'b1, 32'h30);
        redirect_to(32'h10);
        step();
        chk1("pre-reset pred", ifid_pred_taken, 1'b1);
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        chk1("async rst valid", ifid_valid, 1'b0);
        chk32("async rst addr", imem_addr, 32'h0);
        chk32("async rst inst", ifid_inst, NOP);
        chk1("async rst pred", ifid_pred_taken, 1'b0);
        step();
        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_to(32'h10);
        step();
        chk1("bht cleared", ifid_pred_taken, 1'b0);
        chk32("post-reset target", ifid_pred_target, 32'h14);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
